// File: rtl/filter_sched_pkg.sv
// Shared types and constants for the multi-channel FIR scheduler.
// State encoding, default sizing and power-on coefficient values.
package filter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_NUM_TAPS = 4;
  localparam int DEF_DATA_W   = 8;

  localparam int RST_COEF_TAP0 = 1;
  localparam int RST_COEF_TAPN = 0;

  // Reset leaves every channel as a pass-through filter.
  function automatic int rst_coef(input int tap);
    return (tap == 0) ? RST_COEF_TAP0
                      : RST_COEF_TAPN;
  endfunction

endpackage

// File: rtl/filter_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request after ptr wins.
// Grant is one-hot, or all zero when nothing requests.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int W = $clog2(N);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_channel_scheduler.sv
// Time-shared FIR: one MAC serves NUM_CH sample streams,
// each with its own history and coefficient bank.
module filter_channel_scheduler
  import filter_sched_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = 2*DATA_W
                         + $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
  input  logic [$clog2(NUM_TAPS)-1:0]  cfg_tap,
  input  logic [DATA_W-1:0]            cfg_coef,
  output logic                         cfg_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch
);

  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(NUM_TAPS);
  localparam int PW = 2*DATA_W;
  localparam int EW = ACC_W - PW;

  typedef logic signed [DATA_W-1:0] smp_t;

  state_t                   state;
  logic [CW-1:0]            ptr;
  logic [CW-1:0]            cur_ch;
  logic [TW-1:0]            tap;
  logic signed [ACC_W-1:0]  acc;

  smp_t hist [NUM_CH][NUM_TAPS];
  smp_t coef [NUM_CH][NUM_TAPS];

  logic [NUM_CH-1:0]        gnt;
  logic [CW-1:0]            gnt_idx;
  logic                     idle;
  logic                     take;
  logic                     cfg_take;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Handshakes are masked while reset is held, even though
  // the state register already reads IDLE.
  assign idle      = rst_n && (state == IDLE);
  assign in_ready  = (idle && !flush) ? gnt : '0;
  assign take      = |(in_ready & in_valid);
  assign cfg_ready = idle;
  assign cfg_take  = cfg_we && cfg_ready;

  always_comb begin
    gnt_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) gnt_idx = CW'(c);
    end
  end

  assign prod     = hist[cur_ch][tap]
                  * coef[cur_ch][tap];
  assign prod_ext = {{EW{prod[PW-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          hist[c][t] <= '0;
          coef[c][t] <= DATA_W'(rst_coef(t));
        end
      end
    end else begin
      if (cfg_take) begin
        coef[cfg_ch][cfg_tap] <= cfg_coef;
      end
      if (idle && flush) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int t = 0; t < NUM_TAPS; t++) begin
            hist[c][t] <= '0;
          end
        end
      end else if (take) begin
        hist[gnt_idx][0] <=
          in_data[gnt_idx*DATA_W +: DATA_W];
        for (int t = 1; t < NUM_TAPS; t++) begin
          hist[gnt_idx][t] <= hist[gnt_idx][t-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= CW'(NUM_CH-1);
      cur_ch    <= '0;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            cur_ch <= gnt_idx;
            tap    <= '0;
            acc    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          tap <= tap + 1'b1;
          if (tap == TW'(NUM_TAPS-1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle registers the result,
          // then it is held until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc;
            out_ch    <= cur_ch;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= cur_ch;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/filter_channel_scheduler.md
FILTER_CHANNEL_SCHEDULER -- requirements
Module: filter_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sample requesters sharing the filter.
REQ-002 SHALL have parameter NUM_TAPS, default 4, taps per channel.
REQ-003 SHALL have parameter DATA_W, default 8, signed sample and coefficient width.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(NUM_TAPS) (18), signed accumulator width.
REQ-005 Port clk  input  1  single clock, all state on rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port in_valid  input  NUM_CH  per-channel sample valid.
REQ-008 Port in_data  input  NUM_CH*DATA_W  per-channel signed sample, channel c at [c*DATA_W +: DATA_W].
REQ-009 Port in_ready  output  NUM_CH  per-channel accept, at most one bit high.
REQ-010 Port cfg_we  input  1  coefficient write strobe.
REQ-011 Port cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-012 Port cfg_tap  input  $clog2(NUM_TAPS)  target tap.
REQ-013 Port cfg_coef  input  DATA_W  signed coefficient.
REQ-014 Port cfg_ready  output  1  write accepted this cycle.
REQ-015 Port flush  input  1  clear all channel histories.
REQ-016 Port out_valid  output  1  result valid.
REQ-017 Port out_ready  input  1  downstream accept.
REQ-018 Port out_data  output  ACC_W  signed filter result.
REQ-019 Port out_ch  output  $clog2(NUM_CH)  channel of out_data.

Function
REQ-020 SHALL implement FSM IDLE -> MAC -> DONE -> IDLE, one shared multiplier-accumulator.
REQ-021 IDLE: round-robin grant among asserted in_valid, search starting at last granted channel +1 (mod NUM_CH); in_ready[grant]=1 only in IDLE, combinational.
REQ-022 On handshake: shift granted channel history (new sample to tap0, tap k <- tap k-1, oldest dropped), clear accumulator, tap counter=0, record channel, go MAC; other channels' histories unchanged.
REQ-023 MAC: one product history[t]*coef[t] per cycle, sign-extended to ACC_W and added; after t=NUM_TAPS-1 go DONE; exactly NUM_TAPS cycles.
REQ-024 DONE: out_valid=1, out_data/out_ch held stable until out_valid&out_ready; then IDLE, round-robin pointer = served channel.
REQ-025 Latency: out_valid high exactly NUM_TAPS+1 rising edges after accepting edge (5 default); next grant possible in cycle after output handshake.
REQ-026 Accumulation SHALL be full-precision two's complement, no saturation or truncation (4*(-128*-128)=65536 fits 18 bits).
REQ-027 cfg_ready=1 only in IDLE; write with cfg_we&cfg_ready updates coef[cfg_ch][cfg_tap]; cfg_we with cfg_ready low ignored (no queuing).
REQ-028 Write and sample grant in same IDLE cycle: both occur; new coefficient used by that computation.
REQ-029 flush in IDLE: all histories zeroed, in_ready forced 0 that cycle (flush wins); flush outside IDLE ignored.
REQ-030 No in_valid in IDLE: remain IDLE, pointer unchanged.

Reset
REQ-031 rst_n low: state IDLE, pointer NUM_CH-1 (so channel 0 wins first), histories 0, accumulator 0.
REQ-032 Reset coef[c][0]=1, coef[c][t>0]=0 for all c (pass-through).
REQ-033 Reset outputs: in_ready 0, cfg_ready 0 while rst_n low, out_valid 0, out_data 0, out_ch 0.
REQ-034 Reset mid-MAC or in DONE aborts computation; pending result discarded, never presented.

Structure
REQ-035 Shared package filter_sched_pkg SHALL hold state enum (IDLE/MAC/DONE), default parameter values, reset-coefficient constants.
REQ-036 Round-robin arbiter SHALL be sub-module rr_arbiter (request vector, pointer in, one-hot grant out).

Verification
REQ-037 After reset, ch0 sends 8'sd5 -> out_data 5, out_ch 0, out_valid 5 cycles after accept.
REQ-038 Write ch1 coefs {1,2,3,4}, send ch1 samples 1,2,3,4 -> outputs 1, 4, 10, 20.
REQ-039 All four in_valid held, out_ready=1 -> grant order 0,1,2,3,0; no channel starved.
REQ-040 Coefs all -128, ch2 samples all -128 -> fourth result +65536, no overflow.
REQ-041 out_ready low 10 cycles in DONE -> out_data/out_ch stable, in_ready all 0, cfg write ignored.
REQ-042 rst_n low during MAC -> out_valid stays 0; flush with ch0 valid in IDLE -> in_ready 0, next ch0 result uses zero history.
